// File: rtl/ble_scan_sequencer.sv
// BLE advertising-channel scan sequencer: tunes the RF front-end across 37/38/39,
// configures the ble_cdr sniffer per channel, listens, and reports packets to host.
// Ports: clk/resetn/en; start/stop control; cfg_* sampled on start; tune_req/
// tune_channel/tune_ack RF handshake; modify_sniffer_settings/acc_addr/channel to
// ble_cdr; packet_detected/packet_len_in from ble_cdr; pkt_valid/pkt_ready/pkt_len/
// pkt_channel host report; busy, tune_err (sticky), cfg_err (pulse) status.
module ble_scan_sequencer #(
   parameter int MAX_PACKET_LEN = 376,
   parameter int DWELL_W        = 24,
   parameter int SETTLE_CYCLES  = 64,
   parameter int TUNE_TIMEOUT   = 255
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic                              en,
   input  logic                              start,
   input  logic                              stop,
   input  logic [31:0]                       cfg_acc_addr,
   input  logic [2:0]                        cfg_chan_mask,
   input  logic [DWELL_W-1:0]                dwell_cycles,
   output logic                              tune_req,
   output logic [5:0]                        tune_channel,
   input  logic                              tune_ack,
   output logic                              modify_sniffer_settings,
   output logic [31:0]                       acc_addr,
   output logic [5:0]                        channel,
   input  logic                              packet_detected,
   input  logic [$clog2(MAX_PACKET_LEN)-1:0] packet_len_in,
   output logic                              pkt_valid,
   input  logic                              pkt_ready,
   output logic [$clog2(MAX_PACKET_LEN)-1:0] pkt_len,
   output logic [5:0]                        pkt_channel,
   output logic                              busy,
   output logic                              tune_err,
   output logic                              cfg_err
);

   localparam int LW   = $clog2(MAX_PACKET_LEN);
   localparam int TW   = $clog2(TUNE_TIMEOUT + 1);
   localparam int SW   = $clog2(SETTLE_CYCLES + 1);
   localparam logic [31:0] DEF_AA = 32'h6b7d9171;

   typedef enum logic [2:0] {
      IDLE, TUNE, SETTLE, CONFIG, LISTEN, REPORT, HOP
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        cfg_aa_q, cfg_aa_d;
   logic [2:0]         mask_q, mask_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] dcnt_q, dcnt_d;
   logic [1:0]         idx_q, idx_d;
   logic [TW-1:0]      tcnt_q, tcnt_d;
   logic [SW-1:0]      scnt_q, scnt_d;
   logic               pd_prev_q, pd_prev_d;
   logic               tune_req_q, tune_req_d;
   logic [5:0]         tune_ch_q, tune_ch_d;
   logic               mod_q, mod_d;
   logic [31:0]        acc_addr_q, acc_addr_d;
   logic [5:0]         channel_q, channel_d;
   logic               pkt_valid_q, pkt_valid_d;
   logic [LW-1:0]      pkt_len_q, pkt_len_d;
   logic [5:0]         pkt_ch_q, pkt_ch_d;
   logic               tune_err_q, tune_err_d;
   logic               cfg_err_q, cfg_err_d;

   // Index 0/1/2 maps to channel 37/38/39
   function automatic logic [5:0] ch_of(input logic [1:0] i);
      return 6'd37 + {4'd0, i};
   endfunction

   function automatic logic [1:0] first_ch(input logic [2:0] m);
      return m[0] ? 2'd0 : (m[1] ? 2'd1 : 2'd2);
   endfunction

   // Cyclic search for the next enabled channel; falls back to the same one
   function automatic logic [1:0] next_ch(input logic [1:0] i,
                                          input logic [2:0] m);
      logic [1:0] a;
      logic [1:0] b;
      a = (i == 2'd2) ? 2'd0 : i + 2'd1;
      b = (a == 2'd2) ? 2'd0 : a + 2'd1;
      if (m[a])      return a;
      else if (m[b]) return b;
      else           return i;
   endfunction

   always_comb begin
      state_d     = state_q;
      cfg_aa_d    = cfg_aa_q;
      mask_d      = mask_q;
      dwell_d     = dwell_q;
      dcnt_d      = dcnt_q;
      idx_d       = idx_q;
      tcnt_d      = tcnt_q;
      scnt_d      = scnt_q;
      pd_prev_d   = pd_prev_q;
      tune_req_d  = tune_req_q;
      tune_ch_d   = tune_ch_q;
      mod_d       = 1'b0;
      acc_addr_d  = acc_addr_q;
      channel_d   = channel_q;
      pkt_valid_d = pkt_valid_q;
      pkt_len_d   = pkt_len_q;
      pkt_ch_d    = pkt_ch_q;
      tune_err_d  = tune_err_q;
      cfg_err_d   = 1'b0;
      if (!en) begin
         cfg_err_d = cfg_err_q;
      end else if (stop) begin
         state_d     = IDLE;
         pkt_valid_d = 1'b0;
         tune_req_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && cfg_chan_mask == 3'b000) begin
                  cfg_err_d = 1'b1;
               end else if (start) begin
                  cfg_aa_d   = cfg_acc_addr;
                  mask_d     = cfg_chan_mask;
                  dwell_d    = dwell_cycles;
                  tune_err_d = 1'b0;
                  idx_d      = first_ch(cfg_chan_mask);
                  tune_ch_d  = ch_of(first_ch(cfg_chan_mask));
                  tune_req_d = 1'b1;
                  tcnt_d     = '0;
                  state_d    = TUNE;
               end
            end
            TUNE: begin
               if (tune_ack && tune_req_q) begin
                  tune_req_d = 1'b0;
                  scnt_d     = '0;
                  state_d    = SETTLE;
               end else if (tcnt_q == TW'(TUNE_TIMEOUT - 1)) begin
                  tune_req_d = 1'b0;
                  tune_err_d = 1'b1;
                  state_d    = HOP;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            SETTLE: begin
               if (scnt_q == SW'(SETTLE_CYCLES - 1)) begin
                  mod_d      = 1'b1;
                  acc_addr_d = cfg_aa_q;
                  channel_d  = ch_of(idx_q);
                  state_d    = CONFIG;
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
            CONFIG: begin
               pd_prev_d = packet_detected;
               dcnt_d    = '0;
               state_d   = LISTEN;
            end
            LISTEN: begin
               pd_prev_d = packet_detected;
               // Packet edge takes priority over dwell expiry
               if (packet_detected && !pd_prev_q) begin
                  pkt_len_d   = packet_len_in;
                  pkt_ch_d    = ch_of(idx_q);
                  pkt_valid_d = 1'b1;
                  state_d     = REPORT;
               end else if (dwell_q != '0 &&
                            dcnt_q == dwell_q - DWELL_W'(1)) begin
                  state_d = HOP;
               end else begin
                  dcnt_d = dcnt_q + 1'b1;
               end
            end
            REPORT: begin
               if (pkt_ready) begin
                  pkt_valid_d = 1'b0;
                  state_d     = HOP;
               end
            end
            HOP: begin
               idx_d      = next_ch(idx_q, mask_q);
               tune_ch_d  = ch_of(next_ch(idx_q, mask_q));
               tune_req_d = 1'b1;
               tcnt_d     = '0;
               state_d    = TUNE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         cfg_aa_q    <= DEF_AA;
         mask_q      <= '0;
         dwell_q     <= '0;
         dcnt_q      <= '0;
         idx_q       <= '0;
         tcnt_q      <= '0;
         scnt_q      <= '0;
         pd_prev_q   <= 1'b0;
         tune_req_q  <= 1'b0;
         tune_ch_q   <= 6'd37;
         mod_q       <= 1'b0;
         acc_addr_q  <= DEF_AA;
         channel_q   <= 6'd37;
         pkt_valid_q <= 1'b0;
         pkt_len_q   <= '0;
         pkt_ch_q    <= '0;
         tune_err_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_aa_q    <= cfg_aa_d;
         mask_q      <= mask_d;
         dwell_q     <= dwell_d;
         dcnt_q      <= dcnt_d;
         idx_q       <= idx_d;
         tcnt_q      <= tcnt_d;
         scnt_q      <= scnt_d;
         pd_prev_q   <= pd_prev_d;
         tune_req_q  <= tune_req_d;
         tune_ch_q   <= tune_ch_d;
         mod_q       <= mod_d;
         acc_addr_q  <= acc_addr_d;
         channel_q   <= channel_d;
         pkt_valid_q <= pkt_valid_d;
         pkt_len_q   <= pkt_len_d;
         pkt_ch_q    <= pkt_ch_d;
         tune_err_q  <= tune_err_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign tune_req                = tune_req_q;
   assign tune_channel            = tune_ch_q;
   assign modify_sniffer_settings = mod_q;
   assign acc_addr                = acc_addr_q;
   assign channel                 = channel_q;
   assign pkt_valid               = pkt_valid_q;
   assign pkt_len                 = pkt_len_q;
   assign pkt_channel             = pkt_ch_q;
   assign busy                    = (state_q != IDLE);
   assign tune_err                = tune_err_q;
   assign cfg_err                 = cfg_err_q;

endmodule

// File: tb/tb_ble_scan_sequencer.sv
// Directed self-checking bench for ble_scan_sequencer.
// Exercises hop order, settle/dwell timing, reporting, timeouts and aborts.
module tb_ble_scan_sequencer;

   localparam int LW = $clog2(376);
   localparam logic [31:0] DEF_AA = 32'h6b7d9171;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          en = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [31:0]   cfg_acc_addr = '0;
   logic [2:0]    cfg_chan_mask = '0;
   logic [23:0]   dwell_cycles = '0;
   logic          tune_req;
   logic [5:0]    tune_channel;
   logic          tune_ack = 1'b0;
   logic          modify_sniffer_settings;
   logic [31:0]   acc_addr;
   logic [5:0]    channel;
   logic          packet_detected = 1'b0;
   logic [LW-1:0] packet_len_in = '0;
   logic          pkt_valid;
   logic          pkt_ready = 1'b0;
   logic [LW-1:0] pkt_len;
   logic [5:0]    pkt_channel;
   logic          busy;
   logic          tune_err;
   logic          cfg_err;

   int checks = 0;
   int errors = 0;

   ble_scan_sequencer dut (
      .clk(clk), .resetn(resetn), .en(en), .start(start), .stop(stop),
      .cfg_acc_addr(cfg_acc_addr), .cfg_chan_mask(cfg_chan_mask),
      .dwell_cycles(dwell_cycles), .tune_req(tune_req),
      .tune_channel(tune_channel), .tune_ack(tune_ack),
      .modify_sniffer_settings(modify_sniffer_settings),
      .acc_addr(acc_addr), .channel(channel),
      .packet_detected(packet_detected), .packet_len_in(packet_len_in),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_len(pkt_len),
      .pkt_channel(pkt_channel), .busy(busy), .tune_err(tune_err),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_scan(input logic [2:0] m, input logic [23:0] d,
                             input logic [31:0] aa);
      cfg_chan_mask = m;
      dwell_cycles  = d;
      cfg_acc_addr  = aa;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("start_req", 32'(tune_req), 1);
   endtask

   task automatic do_stop();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("stop_busy", 32'(busy), 0);
      chk("stop_req", 32'(tune_req), 0);
   endtask

   // Entered on the first TUNE cycle; leaves on the first LISTEN cycle
   task automatic tune_cfg(input logic [5:0] ch, input logic [31:0] aa);
      int n;
      chk("tune_ch", 32'(tune_channel), 32'(ch));
      cyc(2);
      tune_ack = 1'b1;
      cyc();
      tune_ack = 1'b0;
      chk("ack_drop", 32'(tune_req), 0);
      n = 1;
      while (!modify_sniffer_settings && n < 200) begin
         cyc();
         n++;
      end
      chk("settle_lat", n, 65);
      chk("cfg_ch", 32'(channel), 32'(ch));
      chk("cfg_aa", acc_addr, aa);
      cyc();
      chk("mod_pulse", 32'(modify_sniffer_settings), 0);
   endtask

   // From first LISTEN cycle: dwell cycles of LISTEN, one HOP, then TUNE
   task automatic wait_req(output int n);
      n = 0;
      while (!tune_req && n < 1000) begin
         cyc();
         n++;
      end
   endtask

   initial begin
      int n;
      int k;
      // Reset values
      cyc(3);
      chk("rst_aa", acc_addr, DEF_AA);
      chk("rst_ch", 32'(channel), 37);
      chk("rst_tch", 32'(tune_channel), 37);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_req", 32'(tune_req), 0);
      chk("rst_valid", 32'(pkt_valid), 0);
      chk("rst_mod", 32'(modify_sniffer_settings), 0);
      resetn = 1'b1;
      cyc(2);

      // All channels, dwell 100, no packets
      start_scan(3'b111, 24'd100, 32'h11223344);
      tune_cfg(6'd37, 32'h11223344);
      wait_req(n);
      chk("gap37", n, 101);
      tune_cfg(6'd38, 32'h11223344);
      wait_req(n);
      chk("gap38", n, 101);
      tune_cfg(6'd39, 32'h11223344);
      wait_req(n);
      chk("gap39", n, 101);
      chk("wrap37", 32'(tune_channel), 37);
      do_stop();

      // Mask 101, packet on 39 with back-pressure
      start_scan(3'b101, 24'd100, 32'hcafef00d);
      tune_cfg(6'd37, 32'hcafef00d);
      wait_req(n);
      chk("gap_skip", n, 101);
      tune_cfg(6'd39, 32'hcafef00d);
      cyc(10);
      packet_detected = 1'b1;
      packet_len_in   = 9'd120;
      cyc();
      chk("rep_valid", 32'(pkt_valid), 1);
      chk("rep_len", 32'(pkt_len), 120);
      chk("rep_ch", 32'(pkt_channel), 39);
      packet_len_in = 9'd7;
      n = 0;
      while (pkt_valid && n < 20) begin
         if (n == 5) pkt_ready = 1'b1;
         if (n == 4) chk("rep_len_hold", 32'(pkt_len), 120);
         cyc();
         n++;
      end
      chk("valid_cycles", n, 6);
      pkt_ready = 1'b0;
      packet_detected = 1'b0;
      cyc();
      chk("hop_req", 32'(tune_req), 1);
      chk("hop_ch", 32'(tune_channel), 37);
      do_stop();

      // Tune timeout on 38
      start_scan(3'b011, 24'd100, 32'h0badcafe);
      tune_cfg(6'd37, 32'h0badcafe);
      wait_req(n);
      chk("to_ch", 32'(tune_channel), 38);
      n = 0;
      k = 0;
      while (tune_req && n < 400) begin
         cyc();
         n++;
         if (modify_sniffer_settings) k++;
      end
      chk("to_len", n, 255);
      chk("to_err", 32'(tune_err), 1);
      cyc();
      if (modify_sniffer_settings) k++;
      chk("to_nomod", k, 0);
      chk("to_req", 32'(tune_req), 1);
      chk("to_next", 32'(tune_channel), 37);
      do_stop();
      chk("err_sticky", 32'(tune_err), 1);
      start_scan(3'b111, 24'd100, 32'h0badcafe);
      chk("err_clr", 32'(tune_err), 0);
      do_stop();

      // Empty mask and start+stop collision
      start_scan_zero: begin
         cfg_chan_mask = 3'b000;
         start = 1'b1;
         cyc();
         start = 1'b0;
         chk("cfg_err", 32'(cfg_err), 1);
         chk("cfg_busy", 32'(busy), 0);
         cyc();
         chk("cfg_err_pulse", 32'(cfg_err), 0);
      end
      cfg_chan_mask = 3'b111;
      start = 1'b1;
      stop  = 1'b1;
      cyc();
      start = 1'b0;
      stop  = 1'b0;
      chk("ss_busy", 32'(busy), 0);
      chk("ss_req", 32'(tune_req), 0);

      // Dwell 0 listens forever; stop discards a pending report
      start_scan(3'b001, 24'd0, 32'h55aa55aa);
      tune_cfg(6'd37, 32'h55aa55aa);
      k = 0;
      repeat (10000) begin
         cyc();
         if (!busy || tune_req) k++;
      end
      chk("dwell0", k, 0);
      packet_detected = 1'b1;
      packet_len_in   = 9'd200;
      cyc();
      chk("d0_valid", 32'(pkt_valid), 1);
      chk("d0_len", 32'(pkt_len), 200);
      chk("d0_ch", 32'(pkt_channel), 37);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("abort_valid", 32'(pkt_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      packet_detected = 1'b0;

      // Packet on dwell-expiry cycle, then reset mid-SETTLE
      start_scan(3'b100, 24'd5, 32'h12345678);
      tune_cfg(6'd39, 32'h12345678);
      cyc(4);
      packet_detected = 1'b1;
      packet_len_in   = 9'd33;
      cyc();
      chk("tie_valid", 32'(pkt_valid), 1);
      chk("tie_req", 32'(tune_req), 0);
      chk("tie_len", 32'(pkt_len), 33);
      pkt_ready = 1'b1;
      cyc();
      pkt_ready = 1'b0;
      packet_detected = 1'b0;
      cyc();
      chk("single_req", 32'(tune_req), 1);
      chk("single_ch", 32'(tune_channel), 39);
      tune_ack = 1'b1;
      cyc();
      tune_ack = 1'b0;
      cyc(10);
      resetn = 1'b0;
      #2;
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_ch", 32'(channel), 37);
      chk("mrst_tch", 32'(tune_channel), 37);
      chk("mrst_aa", acc_addr, DEF_AA);
      chk("mrst_valid", 32'(pkt_valid), 0);
      cyc(2);
      resetn = 1'b1;
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ble_scan_sequencer.md
Name: ble_scan_sequencer

Overview:
Control block that sequences the BLE CDR through the three advertising channels (37, 38, 39). For each channel it:
- requests an RF retune and waits for a handshake ack plus a settle time;
- pushes access-address/channel settings into the CDR packet sniffer with a one-cycle `modify_sniffer_settings` pulse;
- listens for a dwell window.

Detected packets are reported to the host over a valid/ready handshake before hopping continues. It sits between the host/config registers, the RF front-end tuner, and `ble_cdr`.

Parameters:
- MAX_PACKET_LEN, 376, maximum packet length in bits; sets the `pkt_len` width to $clog2(MAX_PACKET_LEN).
- DWELL_W, 24, width of the dwell counter and the `dwell_cycles` input.
- SETTLE_CYCLES, 64, clk cycles to wait after `tune_ack` before configuring the sniffer; must be ≥1.
- TUNE_TIMEOUT, 255, clk cycles to wait for `tune_ack` before the channel is skipped.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- en  in  1  global enable; when low, all state and counters hold.
- start  in  1  single-cycle pulse; begins scanning from IDLE.
- stop  in  1  single-cycle pulse; aborts to IDLE from any state.
- cfg_acc_addr  in  32  access address; sampled on `start`.
- cfg_chan_mask  in  3  enabled channels, bit0=37, bit1=38, bit2=39; sampled on `start`.
- dwell_cycles  in  DWELL_W  listen time per channel; 0 = listen indefinitely; sampled on `start`.
- tune_req  out  1  request the RF front-end to tune to `tune_channel`.
- tune_channel  out  6  channel index being requested.
- tune_ack  in  1  RF tuned; accepted only while `tune_req`=1.
- modify_sniffer_settings  out  1  one-cycle pulse to `ble_cdr`.
- acc_addr  out  32  access address to `ble_cdr`.
- channel  out  6  channel to `ble_cdr`.
- packet_detected  in  1  level from `ble_cdr`, synchronous to clk.
- packet_len_in  in  $clog2(MAX_PACKET_LEN)  from `ble_cdr`.
- pkt_valid  out  1  report valid.
- pkt_ready  in  1  host ready.
- pkt_len  out  $clog2(MAX_PACKET_LEN)  captured length.
- pkt_channel  out  6  channel on which the packet was caught.
- busy  out  1  high in every state except IDLE.
- tune_err  out  1  sticky; set on tune timeout; cleared by `start`.
- cfg_err  out  1  one-cycle pulse when `start` arrives with `cfg_chan_mask`=0.

Behaviour:

Reset values:
- All outputs are 0, except `acc_addr` = 32'h6b7d9171 and `channel` = `tune_channel` = 37.
- State = IDLE; all counters = 0.

Enable:
- When `en`=0, state, counters and outputs hold. `modify_sniffer_settings` is forced to 0.

States:
- IDLE:
  - `start` with mask≠0 latches the configuration, clears `tune_err`, selects the lowest enabled channel, and goes to TUNE.
  - `start` with mask=0 pulses `cfg_err` and stays in IDLE.
- TUNE:
  - `tune_req`=1 and `tune_channel`=current channel; the timeout counter increments.
  - `tune_ack` → go to SETTLE and drop `tune_req` on the same edge.
  - Counter reaches TUNE_TIMEOUT without ack → set `tune_err` and go to HOP.
- SETTLE: count SETTLE_CYCLES cycles, then go to CONFIG.
- CONFIG (exactly 1 cycle):
  - Drive `acc_addr` and `channel` from the latched values; `modify_sniffer_settings`=1.
  - Register `packet_detected` as the edge-detect baseline.
  - Go to LISTEN.
- LISTEN:
  - The dwell counter starts at 0 on entry.
  - Rising edge of `packet_detected` (current=1, previous=0) → capture `packet_len_in` into `pkt_len` and the current channel into `pkt_channel`; go to REPORT.
  - Otherwise, when `dwell_cycles`≠0 and the counter equals `dwell_cycles`-1 → go to HOP.
  - A packet edge on the same cycle as dwell expiry: the packet wins.
- REPORT:
  - `pkt_valid`=1; `pkt_len` and `pkt_channel` are stable until the handshake.
  - On `pkt_valid` & `pkt_ready`, drop valid next cycle and go to HOP.
  - No further packets are captured while in REPORT.
- HOP (1 cycle): advance to the next enabled channel in the cyclic order 37→38→39→37, skipping masked channels. With a single enabled channel, retune to the same channel. Go to TUNE.

Stop:
- `stop` has priority over every transition, including `start` in the same cycle.
- Next state is IDLE. `pkt_valid`, `tune_req` and `modify_sniffer_settings` deassert on that edge; an unaccepted report is discarded.
- `acc_addr` and `channel` hold their last values.

Latency:
- `start` to `tune_req`=1: 1 cycle.
- `tune_ack` to `modify_sniffer_settings` pulse: SETTLE_CYCLES+1 cycles.
- Packet edge to `pkt_valid`: 1 cycle.

Reset mid-operation returns immediately to the reset values.

Test Plan:
- Start with mask=3'b111, dwell=100, `tune_ack` 2 cycles after each `tune_req`, no packets → channel sequence 37,38,39,37; one `modify_sniffer_settings` pulse per channel; LISTEN lasts exactly 100 cycles each.
- Mask=3'b101; `packet_detected` rises 10 cycles into LISTEN on 39 with `packet_len_in`=120; hold `pkt_ready` low 5 cycles → `pkt_valid` held 6 cycles with `pkt_len`=120 and `pkt_channel`=39; then hop to 37.
- `tune_ack` never asserted on 38, mask=3'b011 → `tune_err`=1 after 255 cycles; next TUNE is on 37 with no sniffer pulse for 38; a new `start` clears `tune_err`.
- Mask=0 `start` → `cfg_err` is a one-cycle pulse, `busy` stays 0. Same-cycle `start`+`stop` → remains IDLE.
- `stop` during REPORT with `pkt_ready`=0 → next cycle `pkt_valid`=0 and `busy`=0. Dwell=0 → LISTEN persists 10k cycles with no hop.
- Packet edge on the exact dwell-expiry cycle → REPORT is entered, not HOP. `resetn` pulse mid-SETTLE → all outputs return to reset values, `channel`=37.
